// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, single-outstanding instruction-memory requester
// and 2-entry {ir, ir_pc} buffer with redirect flush.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [9:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        ir_valid,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    input  logic        ir_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_fetch_pc;
    logic [15:0] w_fetch_pc_nxt;
    logic [15:0] w_redir_pc;

    logic [15:0] r_buf_ir [2];
    logic [15:0] r_buf_pc [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic [1:0]  w_count_nxt;

    logic        w_launch;
    logic        w_req;
    logic        w_push;
    logic        w_pop;

    // Request, accept and buffer-occupancy decode for the current cycle
    always_comb begin
        w_redir_pc  = redirect_pc & 16'hFFFC;
        w_launch    = (r_state == S_IDLE) && (r_count != 2'd2) && !redirect;
        w_req       = (r_state == S_REQ) || (r_state == S_DROP) || w_launch;
        w_push      = imem_ack && w_req && (r_state != S_DROP) && !redirect;
        w_pop       = ir_ready && (r_count != 2'd0) && !redirect;
        w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
    end

    // Next-state and next fetch PC; redirect takes priority over everything
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        if (redirect) begin
            w_fetch_pc_nxt = w_redir_pc;
            w_state_nxt    = (w_req && !imem_ack) ? S_DROP : S_IDLE;
        end else if (w_push) begin
            w_fetch_pc_nxt = r_fetch_pc + 16'd4;
            w_state_nxt    = (w_count_nxt == 2'd2) ? S_IDLE : S_REQ;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_launch) w_state_nxt = S_REQ;
                S_REQ:  w_state_nxt = S_REQ;
                S_DROP: if (imem_ack) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State and fetch PC registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    // Two-entry instruction buffer; a redirect empties it
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_buf_ir[i] <= 16'h0000;
                r_buf_pc[i] <= 16'h0000;
            end
        end else if (redirect) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf_ir[r_wr_ptr] <= imem_data;
                r_buf_pc[r_wr_ptr] <= r_fetch_pc;
                r_wr_ptr           <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
        end
    end

    // Outputs; the request is held low while reset is asserted
    always_comb begin
        imem_req  = w_req && !reset;
        imem_addr = r_fetch_pc[11:2];
        ir_valid  = (r_count != 2'd0);
        ir        = r_buf_ir[r_rd_ptr];
        ir_pc     = r_buf_pc[r_rd_ptr];
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed tests for instr_fetch with a latency-programmable
// memory model; a second instance runs with RESET_PC = 16'hFFFC.
module tb_instr_fetch;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ir_valid;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_ready;

    logic        w_reset;
    logic        w_req;
    logic [9:0]  w_addr;
    logic        w_ack;
    logic [15:0] w_data;
    logic        w_redirect;
    logic [15:0] w_redirect_pc;
    logic        w_ir_valid;
    logic [15:0] w_ir;
    logic [15:0] w_ir_pc;
    logic        w_ready;

    int lat;
    int lat2;
    int wcnt;
    int wcnt2;
    logic force_ack;

    int n_checks;
    int n_fail;

    instr_fetch u_dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready)
    );

    instr_fetch #(.RESET_PC(16'hFFFC)) u_dut_w (
        .clock       (clock),
        .reset       (w_reset),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ack    (w_ack),
        .imem_data   (w_data),
        .redirect    (w_redirect),
        .redirect_pc (w_redirect_pc),
        .ir_valid    (w_ir_valid),
        .ir          (w_ir),
        .ir_pc       (w_ir_pc),
        .ir_ready    (w_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory models: word at address a is 16'h5100 + a; ack after lat cycles
    assign imem_ack  = force_ack || (imem_req && (lat == 0 || wcnt >= lat));
    assign imem_data = 16'h5100 + {6'd0, imem_addr};
    assign w_ack     = w_req && (lat2 == 0 || wcnt2 >= lat2);
    assign w_data    = 16'h5100 + {6'd0, w_addr};

    always @(posedge clock) begin
        if (!imem_req || imem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (!w_req || w_ack) wcnt2 <= 0;
        else wcnt2 <= wcnt2 + 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        force_ack = 1'b0;
        ir_ready = 1'b0;
        lat = 0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        #1;
        n_checks++;
        if (ir_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ir_valid got=%b exp=0", ir_valid);
        end
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_imem_req got=%b exp=0", imem_req);
        end
        n_checks++;
        if (ir !== 16'h0000 || ir_pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_ir got=%h/%h exp=0000/0000", ir, ir_pc);
        end
        n_checks++;
        if (imem_addr !== 10'h000) begin
            n_fail++;
            $display("FAIL rst_imem_addr got=%h exp=000", imem_addr);
        end
    endtask

    task automatic test_straight();
        logic [15:0] exp_pc;
        logic [15:0] exp_ir;
        do_reset();
        ir_ready = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin
            n_fail++;
            $display("FAIL straight_first_req got=%b/%h exp=1/000", imem_req, imem_addr);
        end
        n_checks++;
        if (ir_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL straight_c0_valid got=%b exp=0", ir_valid);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            exp_pc = 16'(k * 4);
            exp_ir = 16'h5100 + 16'(k);
            n_checks++;
            if (ir_valid !== 1'b1 || ir_pc !== exp_pc || ir !== exp_ir) begin
                n_fail++;
                $display("FAIL straight_%0d got=%b/%h/%h exp=1/%h/%h",
                         k, ir_valid, ir_pc, ir, exp_pc, exp_ir);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_pc;
        logic [15:0] exp_ir;
        do_reset();
        for (int c = 1; c < 5; c++) step();
        #1;
        n_checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'h0000 || ir !== 16'h5100) begin
            n_fail++;
            $display("FAIL bp_head got=%b/%h/%h exp=1/0000/5100", ir_valid, ir_pc, ir);
        end
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_req_low got=%b exp=0", imem_req);
        end
        step();
        ir_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_pc = 16'(k * 4);
            exp_ir = 16'h5100 + 16'(k);
            n_checks++;
            if (ir_valid !== 1'b1 || ir_pc !== exp_pc || ir !== exp_ir) begin
                n_fail++;
                $display("FAIL bp_drain_%0d got=%b/%h/%h exp=1/%h/%h",
                         k, ir_valid, ir_pc, ir, exp_pc, exp_ir);
            end
            step();
        end
    endtask

    task automatic test_redirect_drop();
        logic [15:0] got_pc[$];
        logic [15:0] got_ir[$];
        logic [15:0] exp_pc [3];
        logic [15:0] exp_ir [3];
        bit arm;
        bit fired;
        bit post;
        exp_pc = '{16'h0000, 16'h0004, 16'h0020};
        exp_ir = '{16'h5100, 16'h5101, 16'h5108};
        arm = 1'b0;
        fired = 1'b0;
        post = 1'b0;
        do_reset();
        lat = 3;
        ir_ready = 1'b1;
        for (int c = 0; c < 60 && got_pc.size() < 3; c++) begin
            #1;
            if (ir_valid && ir_ready && !redirect) begin
                got_pc.push_back(ir_pc);
                got_ir.push_back(ir);
            end
            if (redirect) begin
                n_checks++;
                if (imem_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL drop_outstanding got=%b exp=1", imem_req);
                end
            end
            if (post) begin
                n_checks++;
                if (ir_valid !== 1'b0 || imem_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL drop_after got=%b/%b exp=0/1", ir_valid, imem_req);
                end
            end
            post = redirect;
            if (!fired && imem_req && imem_addr == 10'd2) arm = 1'b1;
            step();
            redirect = 1'b0;
            if (arm && !fired) begin
                redirect = 1'b1;
                redirect_pc = 16'h0023;
                fired = 1'b1;
            end
        end
        n_checks++;
        if (got_pc.size() != 3) begin
            n_fail++;
            $display("FAIL drop_count got=%0d exp=3", got_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got_pc[i] !== exp_pc[i] || got_ir[i] !== exp_ir[i]) begin
                    n_fail++;
                    $display("FAIL drop_seq_%0d got=%h/%h exp=%h/%h",
                             i, got_pc[i], got_ir[i], exp_pc[i], exp_ir[i]);
                end
            end
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        step();
        step();
        ir_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        force_ack = 1'b1;
        #1;
        n_checks++;
        if (ir_valid !== 1'b1 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pre got=%b/%b exp=1/0", ir_valid, imem_req);
        end
        step();
        redirect = 1'b0;
        force_ack = 1'b0;
        #1;
        n_checks++;
        if (ir_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_empty got=%b exp=0", ir_valid);
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h040) begin
            n_fail++;
            $display("FAIL full_newreq got=%b/%h exp=1/040", imem_req, imem_addr);
        end
        step();
        #1;
        n_checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'h0100 || ir !== 16'h5140) begin
            n_fail++;
            $display("FAIL full_first got=%b/%h/%h exp=1/0100/5140", ir_valid, ir_pc, ir);
        end
        step();
        #1;
        n_checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'h0104 || ir !== 16'h5141) begin
            n_fail++;
            $display("FAIL full_second got=%b/%h/%h exp=1/0104/5141", ir_valid, ir_pc, ir);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ir_ready = 1'b1;
        step();
        step();
        redirect = 1'b1;
        redirect_pc = 16'h0042;
        #1;
        n_checks++;
        if (imem_ack !== 1'b1 || ir_pc !== 16'h0004) begin
            n_fail++;
            $display("FAIL b2b_pre got=%b/%h exp=1/0004", imem_ack, ir_pc);
        end
        step();
        redirect = 1'b0;
        #1;
        n_checks++;
        if (ir_valid !== 1'b0 || imem_addr !== 10'h010) begin
            n_fail++;
            $display("FAIL b2b_flush got=%b/%h exp=0/010", ir_valid, imem_addr);
        end
        step();
        #1;
        n_checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'h0040 || ir !== 16'h5110) begin
            n_fail++;
            $display("FAIL b2b_first got=%b/%h/%h exp=1/0040/5110", ir_valid, ir_pc, ir);
        end
        step();
        #1;
        n_checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'h0044 || ir !== 16'h5111) begin
            n_fail++;
            $display("FAIL b2b_second got=%b/%h/%h exp=1/0044/5111", ir_valid, ir_pc, ir);
        end
    endtask

    task automatic test_wrap();
        w_ready = 1'b1;
        lat2 = 0;
        step();
        w_reset = 1'b0;
        #1;
        n_checks++;
        if (w_req !== 1'b1 || w_addr !== 10'h3FF) begin
            n_fail++;
            $display("FAIL wrap_req0 got=%b/%h exp=1/3ff", w_req, w_addr);
        end
        step();
        #1;
        n_checks++;
        if (w_ir_valid !== 1'b1 || w_ir_pc !== 16'hFFFC || w_ir !== 16'h54FF) begin
            n_fail++;
            $display("FAIL wrap_first got=%b/%h/%h exp=1/fffc/54ff", w_ir_valid, w_ir_pc, w_ir);
        end
        n_checks++;
        if (w_addr !== 10'h000) begin
            n_fail++;
            $display("FAIL wrap_addr got=%h exp=000", w_addr);
        end
        step();
        #1;
        n_checks++;
        if (w_ir_valid !== 1'b1 || w_ir_pc !== 16'h0000 || w_ir !== 16'h5100) begin
            n_fail++;
            $display("FAIL wrap_second got=%b/%h/%h exp=1/0000/5100", w_ir_valid, w_ir_pc, w_ir);
        end
        step();
        lat2 = 3;
        #1;
        n_checks++;
        if (w_req !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_pending got=%b exp=1", w_req);
        end
        step();
        w_reset = 1'b1;
        #1;
        n_checks++;
        if (w_req !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_rst_req got=%b exp=0", w_req);
        end
        step();
        w_reset = 1'b0;
        lat2 = 0;
        #1;
        n_checks++;
        if (w_ir_valid !== 1'b0 || w_ir !== 16'h0000 || w_ir_pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_rst_state got=%b/%h/%h exp=0/0000/0000", w_ir_valid, w_ir, w_ir_pc);
        end
        n_checks++;
        if (w_req !== 1'b1 || w_addr !== 10'h3FF) begin
            n_fail++;
            $display("FAIL wrap_rst_req1 got=%b/%h exp=1/3ff", w_req, w_addr);
        end
        step();
        #1;
        n_checks++;
        if (w_ir_valid !== 1'b1 || w_ir_pc !== 16'hFFFC) begin
            n_fail++;
            $display("FAIL wrap_rst_pc got=%b/%h exp=1/fffc", w_ir_valid, w_ir_pc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        ir_ready = 1'b0;
        force_ack = 1'b0;
        lat = 0;
        w_reset = 1'b1;
        w_redirect = 1'b0;
        w_redirect_pc = 16'h0000;
        w_ready = 1'b0;
        lat2 = 0;
        test_reset();
        test_straight();
        test_backpressure();
        test_redirect_drop();
        test_redirect_full();
        test_back_to_back();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 RESET_PC, 16'h0000, byte address loaded into the fetch PC on reset.
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-high; sampled on posedge clock.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  10  word address to instruction memory, equal to fetch_pc[11:2].
REQ-006 imem_ack  input  1  memory response strobe; imem_data is valid in the same cycle.
REQ-007 imem_data  input  16  instruction word returned with imem_ack.
REQ-008 redirect  input  1  branch-taken or jump; flushes the fetch stream.
REQ-009 redirect_pc  input  16  new byte-address fetch target.
REQ-010 ir_valid  output  1  ir and ir_pc hold a valid instruction.
REQ-011 ir  output  16  instruction word at the buffer head.
REQ-012 ir_pc  output  16  byte address of ir.
REQ-013 ir_ready  input  1  downstream consumes the head when ir_valid && ir_ready.

Function
REQ-014 The block SHALL hold a 16-bit byte-address fetch_pc and a 2-entry FIFO of {ir, ir_pc} pairs.
REQ-015 The block SHALL have three states:
  - IDLE: no request outstanding.
  - REQ: request outstanding, response to be kept.
  - DROP: request outstanding, response to be discarded.
REQ-016 IDLE -> REQ SHALL occur when FIFO count < 2 and redirect = 0; imem_req rises in that same cycle (Mealy).
REQ-017 imem_req SHALL be high in REQ and DROP; imem_addr SHALL stay stable until imem_ack; at most one request SHALL be outstanding.
REQ-018 An ack in REQ with no redirect SHALL:
  - push {imem_data, fetch_pc};
  - set fetch_pc += 4, wrapping mod 2^16;
  - go to REQ if the post-update count is < 2, else IDLE.
REQ-019 An ack in DROP SHALL discard imem_data and go to IDLE; fetch_pc SHALL be unchanged.
REQ-020 A redirect in any state SHALL:
  - empty the FIFO;
  - load fetch_pc <= {redirect_pc[15:2], 2'b00};
  - discard any ack in that cycle.
REQ-021 Redirect next-state rules:
  - With a request outstanding and no ack in the same cycle: next state DROP.
  - Otherwise: next state IDLE.
  - A redirect while in DROP SHALL update fetch_pc and remain in DROP.
REQ-022 Redirect priority SHALL be over push, pop and the reset-free state update; ir_valid SHALL be 0 in the cycle after a redirect.
REQ-023 ir_valid SHALL equal (count != 0); ir and ir_pc SHALL come from the FIFO head, combinationally.
REQ-024 A simultaneous push and pop SHALL leave count unchanged and preserve order; a pop with count = 0 SHALL be ignored.
REQ-025 With zero-wait memory (ack in the request cycle), latency from request to ir_valid SHALL be 1 cycle; sustained throughput SHALL be 1 instruction per cycle while ir_ready = 1.
REQ-026 fetch_pc bits [15:12] SHALL NOT affect imem_addr; addresses alias every 4 KB.

Reset
REQ-027 Reset SHALL set the following on the next posedge:
  - fetch_pc = RESET_PC, state = IDLE, count = 0;
  - ir_valid = 0, imem_req = 0, ir = 16'h0000, ir_pc = 16'h0000.
REQ-028 Reset SHALL override redirect and ack; a request outstanding at reset SHALL be abandoned, and the memory model SHALL tolerate req dropping without ack.
REQ-029 imem_req SHALL first rise in the first cycle with reset = 0.

Verification
REQ-030 Straight-line fetch:
  - Stimulus: zero-wait memory returning word n = 16'h5100 + n; ir_ready = 1.
  - Response: ir_pc sequence 0, 4, 8, 12 on consecutive cycles starting 1 cycle after reset release; ir = 5100, 5101, 5102, 5103.
REQ-031 Backpressure:
  - Stimulus: ir_ready = 0 for 5 cycles.
  - Response: 2 entries buffered (pc 0, 4); imem_req = 0; no word lost or duplicated after ir_ready = 1.
REQ-032 Redirect with outstanding request:
  - Stimulus: memory with 3-cycle ack latency; redirect_pc = 16'h0023 asserted 1 cycle after the request for pc 8.
  - Response: the pc-8 data is dropped; the next ir_pc is 16'h0020.
REQ-033 Redirect coincident with ack and pop:
  - Stimulus: FIFO full, ack, ir_ready and redirect (target 16'h0100) all in one cycle.
  - Response: FIFO empty next cycle; first new ir_pc = 16'h0100.
REQ-034 Wrap and reset:
  - Stimulus: RESET_PC = 16'hFFFC, fetch 2 words, then reset mid-request.
  - Response: ir_pc FFFC then 0000; imem_addr 10'h3FF then 10'h000; after reset, ir_valid = 0 and the next ir_pc = FFFC.
